cursor_blink_painter: RTL and testbench

//  Blinks the paint cursor on the LED framebuffer. Consumes the black-time timeout (CN) of the contar_negro timer.

---
 rtl/cursor_blink_painter_pkg.sv | 54 +++++
 rtl/cursor_blink_painter.sv | 152 +++++++++++++++
 tb/tb_cursor_blink_painter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cursor_blink_painter_pkg.sv
// Shared definitions for the paint-mode cursor blinker: default widths,
// colour constants, FSM state and exit-cause encodings, and the
// state-to-control decode used to build the registered outputs.
package cursor_blink_painter_pkg;

  localparam int X_W_DEF     = 5;
  localparam int Y_W_DEF     = 5;
  localparam int COLOR_W_DEF = 3;

  localparam logic [2:0] COLOR_BLACK = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_DRAW    = 3'd2,
    S_ARM     = 3'd3,
    S_WAIT    = 3'd4,
    S_RESTORE = 3'd5
  } state_e;

  // Why WAIT was left towards RESTORE; decides where RESTORE goes next.
  typedef enum logic [1:0] {
    CAUSE_TIMEOUT = 2'd0,
    CAUSE_MOVE    = 2'd1,
    CAUSE_DISABLE = 2'd2
  } cause_e;

  typedef struct packed {
    logic timer_init;
    logic timer_rst;
    logic mem_req;
    logic mem_we;
    logic busy;
  } ctrl_t;

  // Control outputs as a pure function of state. IDLE keeps the timer
  // cleared so the first phase after enabling always starts from zero.
  function automatic ctrl_t ctrl_decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE:    c.timer_rst  = 1'b1;
      S_RD:      c.mem_req    = 1'b1;
      S_DRAW:    begin c.mem_req = 1'b1; c.mem_we = 1'b1; end
      S_ARM:     c.timer_rst  = 1'b1;
      S_WAIT:    c.timer_init = 1'b1;
      S_RESTORE: begin c.mem_req = 1'b1; c.mem_we = 1'b1; end
      default:   c.timer_rst  = 1'b1;
    endcase
    c.busy = (s != S_IDLE);
    return c;
  endfunction

endpackage

// File: rtl/cursor_blink_painter.sv
// Cursor blinker for the LED framebuffer. Reads the pixel under the cursor,
// paints CURSOR_COLOR over it, then alternates paint/restore once per timer
// timeout. Leaving paint mode or moving the cursor restores the pixel first.
//
//  state   | meaning
//  IDLE    | blinking off, timer held cleared
//  RD      | reading the pixel under the cursor into saved_pix
//  DRAW    | writing CURSOR_COLOR at the cursor
//  ARM     | one-cycle timer clear so each phase gets a fresh count
//  WAIT    | timer running; watch for timeout, move or disable
//  RESTORE | writing saved_pix back at the old cursor address
module cursor_blink_painter
  import cursor_blink_painter_pkg::*;
#(
  parameter int                 X_W          = X_W_DEF,
  parameter int                 Y_W          = Y_W_DEF,
  parameter int                 COLOR_W      = COLOR_W_DEF,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = COLOR_W'(COLOR_BLACK)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [X_W-1:0]       cursor_x,
  input  logic [Y_W-1:0]       cursor_y,
  input  logic                 timer_done,
  output logic                 timer_init,
  output logic                 timer_rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [X_W+Y_W-1:0]   mem_addr,
  output logic [COLOR_W-1:0]   mem_wdata,
  input  logic                 mem_ack,
  input  logic [COLOR_W-1:0]   mem_rdata,
  output logic                 cursor_shown,
  output logic                 busy
);

  localparam int ADDR_W = X_W + Y_W;

  state_e               state_q, state_d;
  cause_e               cause_q, cause_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COLOR_W-1:0]   saved_q, saved_d;
  logic                 shown_q, shown_d;
  ctrl_t                ctrl_q;
  logic [ADDR_W-1:0]    cur_addr;

  assign cur_addr = {cursor_y, cursor_x};

  // Next-state logic. Enable and cursor changes are only looked at in WAIT,
  // so a memory access in flight is always carried through to its ack.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    addr_d  = addr_q;
    saved_d = saved_q;
    shown_d = shown_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          addr_d  = cur_addr;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (mem_ack) begin
          saved_d = mem_rdata;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (mem_ack) begin
          shown_d = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A move or disable beats a coincident timeout; a disable beats a move.
        if (!enable || (cur_addr != addr_q)) begin
          cause_d = !enable ? CAUSE_DISABLE : CAUSE_MOVE;
          if (shown_q) begin
            state_d = S_RESTORE;
          end else if (!enable) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = cur_addr;
            state_d = S_RD;
          end
        end else if (timer_done) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = shown_q ? S_RESTORE : S_DRAW;
        end
      end
      S_RESTORE: begin
        if (mem_ack) begin
          shown_d = 1'b0;
          case (cause_q)
            CAUSE_DISABLE: state_d = S_IDLE;
            CAUSE_MOVE: begin
              addr_d  = cur_addr;
              state_d = S_RD;
            end
            default: state_d = S_ARM;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath registers and control outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_TIMEOUT;
      addr_q  <= '0;
      saved_q <= '0;
      shown_q <= 1'b0;
      ctrl_q  <= ctrl_decode(S_IDLE);
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      saved_q <= saved_d;
      shown_q <= shown_d;
      ctrl_q  <= ctrl_decode(state_d);
    end
  end

  // Memory port mux: address and data are driven only while a request is up.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (ctrl_q.mem_req) begin
      mem_addr = addr_q;
    end
    if (ctrl_q.mem_req && ctrl_q.mem_we) begin
      mem_wdata = (state_q == S_RESTORE) ? saved_q : CURSOR_COLOR;
    end
  end

  assign timer_init   = ctrl_q.timer_init;
  assign timer_rst    = ctrl_q.timer_rst;
  assign mem_req      = ctrl_q.mem_req;
  assign mem_we       = ctrl_q.mem_we;
  assign busy         = ctrl_q.busy;
  assign cursor_shown = shown_q;

endmodule

// File: tb/tb_cursor_blink_painter.sv
// Directed bench for cursor_blink_painter with a framebuffer model that
// acks after a programmable latency and logs every read and write.
module tb_cursor_blink_painter;

  localparam logic [9:0] A53 = 10'd163; // {y=5, x=3}
  localparam logic [9:0] A54 = 10'd164; // {y=5, x=4}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] cursor_x = 5'd3;
  logic [4:0] cursor_y = 5'd5;
  logic       timer_done = 1'b0;
  logic       timer_init, timer_rst, mem_req, mem_we, mem_ack, cursor_shown, busy;
  logic [9:0] mem_addr;
  logic [2:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad = 0;
  int lat = 1;

  typedef struct packed { logic [9:0] a; logic [2:0] d; } wr_t;
  wr_t        wq[$];
  logic [9:0] rq[$];
  logic [2:0] fb [1024];
  int         wcnt = 0;
  int         rst_pulses = 0;
  int         wait_entries = 0;
  logic       init_prev = 1'b0;
  string      state_name;

  cursor_blink_painter dut (
    .clk(clk), .rst(rst), .enable(enable), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .timer_done(timer_done), .timer_init(timer_init), .timer_rst(timer_rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cursor_shown(cursor_shown), .busy(busy)
  );

  always #5 clk = ~clk;

  // Framebuffer model: ack arrives lat cycles after the request is seen.
  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (rst) begin
      wcnt <= 0;
      for (int i = 0; i < 1024; i++) fb[i] <= 3'b000;
      fb[A53] <= 3'b101;
      fb[A54] <= 3'b110;
    end else if (mem_req && !mem_ack) begin
      if (wcnt == lat - 1) begin
        wcnt    <= 0;
        mem_ack <= 1'b1;
        if (mem_we) begin
          fb[mem_addr] <= mem_wdata;
          wq.push_back({mem_addr, mem_wdata});
        end else begin
          mem_rdata <= fb[mem_addr];
          rq.push_back(mem_addr);
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Event counters: ARM pulses (timer_rst while busy) and entries into WAIT.
  always @(negedge clk) begin
    state_name = dut.state_q.name();
    if (timer_rst && busy) rst_pulses++;
    if (timer_init && !init_prev) wait_entries++;
    init_prev = timer_init;
  end

  task automatic wait_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (timer_init) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; timer_done = 1'b0;
    cursor_x = 5'd3; cursor_y = 5'd5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_blink(output bit ok);
    do_reset();
    enable = 1'b1;
    wait_wait(ok);
  endtask

  task automatic pulse_done();
    timer_done = 1'b1;
    @(negedge clk);
    timer_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    total++; if (timer_rst !== 1'b1) begin bad++; $display("FAIL reset_trst got=%b exp=1", timer_rst); end
    total++; if (timer_init !== 1'b0) begin bad++; $display("FAIL reset_tinit got=%b exp=0", timer_init); end
    total++; if (cursor_shown !== 1'b0) begin bad++; $display("FAIL reset_shown got=%b exp=0", cursor_shown); end
    total++; if (mem_addr !== 10'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int wb = wq.size();
    int rb = rq.size();
    start_blink(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_wait1 timeout state=%s", state_name); end
    total++; if (rq.size() != rb + 1 || rq[rb] !== A53) begin bad++; $display("FAIL basic_read nreads=%0d exp=1 addr exp=%0d", rq.size() - rb, A53); end
    total++; if (wq.size() != wb + 1 || wq[wb] !== {A53, 3'b000}) begin bad++; $display("FAIL basic_draw nwrites=%0d exp=1 (addr 163 data 000)", wq.size() - wb); end
    total++; if (cursor_shown !== 1'b1) begin bad++; $display("FAIL basic_shown1 got=%b exp=1", cursor_shown); end
    pulse_done();
    wait_wait(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_wait2 timeout state=%s", state_name); end
    total++; if (wq.size() != wb + 2 || wq[wb+1] !== {A53, 3'b101}) begin bad++; $display("FAIL basic_restore nwrites=%0d exp=2 (addr 163 data 101)", wq.size() - wb); end
    total++; if (cursor_shown !== 1'b0) begin bad++; $display("FAIL basic_shown0 got=%b exp=0", cursor_shown); end
  endtask

  task automatic test_three_timeouts();
    bit ok;
    bit all_ok = 1'b1;
    int wb = wq.size();
    int pb = rst_pulses;
    int eb = wait_entries;
    wr_t exp [4];
    exp[0] = {A53, 3'b000}; exp[1] = {A53, 3'b101}; exp[2] = {A53, 3'b000}; exp[3] = {A53, 3'b101};
    start_blink(ok);
    all_ok &= ok;
    for (int i = 0; i < 3; i++) begin
      pulse_done();
      wait_wait(ok);
      all_ok &= ok;
    end
    total++; if (!all_ok) begin bad++; $display("FAIL three_wait timeout state=%s", state_name); end
    total++; if (wq.size() != wb + 4) begin bad++; $display("FAIL three_nwrites got=%0d exp=4", wq.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      if (wq.size() > wb + i) begin
        total++; if (wq[wb+i] !== exp[i]) begin bad++; $display("FAIL three_write%0d got=%h exp=%h", i, wq[wb+i], exp[i]); end
      end
    end
    total++; if (rst_pulses - pb != 4) begin bad++; $display("FAIL three_arm_pulses got=%0d exp=4", rst_pulses - pb); end
    total++; if (wait_entries - eb != 4) begin bad++; $display("FAIL three_wait_entries got=%0d exp=4", wait_entries - eb); end
  endtask

  task automatic test_move();
    bit ok, ok2;
    int wb = wq.size();
    int rb = rq.size();
    start_blink(ok);
    cursor_x = 5'd4;
    @(negedge clk);
    wait_wait(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL move_wait timeout state=%s", state_name); end
    total++; if (wq.size() != wb + 3 || wq[wb+1] !== {A53, 3'b101} || wq[wb+2] !== {A54, 3'b000}) begin bad++; $display("FAIL move_writes nwrites=%0d exp=3 (restore 163/101 then draw 164/000)", wq.size() - wb); end
    total++; if (rq.size() != rb + 2 || rq[rb+1] !== A54) begin bad++; $display("FAIL move_read nreads=%0d exp=2 second exp addr=%0d", rq.size() - rb, A54); end
    total++; if (cursor_shown !== 1'b1) begin bad++; $display("FAIL move_shown got=%b exp=1", cursor_shown); end
  endtask

  task automatic test_disable();
    bit ok, ok2;
    int wb = wq.size();
    start_blink(ok);
    enable = 1'b0;
    @(negedge clk);
    wait_idle(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL dis_idle timeout state=%s", state_name); end
    total++; if (wq.size() != wb + 2 || wq[wb+1] !== {A53, 3'b101}) begin bad++; $display("FAIL dis_restore nwrites=%0d exp=2 (163/101)", wq.size() - wb); end
    total++; if (cursor_shown !== 1'b0) begin bad++; $display("FAIL dis_shown got=%b exp=0", cursor_shown); end
    total++; if (timer_rst !== 1'b1) begin bad++; $display("FAIL dis_trst got=%b exp=1", timer_rst); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL dis_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_simultaneous();
    bit ok, ok2;
    int wb = wq.size();
    int rb = rq.size();
    start_blink(ok);
    cursor_x = 5'd4;
    pulse_done();
    wait_wait(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL sim_wait timeout state=%s", state_name); end
    total++; if (wq.size() != wb + 3) begin bad++; $display("FAIL sim_nwrites got=%0d exp=3", wq.size() - wb); end
    total++; if (wq.size() >= wb + 3 && (wq[wb+1] !== {A53, 3'b101} || wq[wb+2] !== {A54, 3'b000})) begin bad++; $display("FAIL sim_writes got=%h,%h exp=%h,%h", wq[wb+1], wq[wb+2], {A53, 3'b101}, {A54, 3'b000}); end
    total++; if (rq.size() != rb + 2 || rq[rb+1] !== A54) begin bad++; $display("FAIL sim_read nreads=%0d exp=2 (second at 164)", rq.size() - rb); end
  endtask

  task automatic test_slow_memory();
    bit ok = 1'b0;
    bit ok2;
    int wb = wq.size();
    int pb = rst_pulses;
    lat = 4;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL slow_draw_start timeout state=%s", state_name); end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== A53 || mem_wdata !== 3'b000) begin
        bad++; $display("FAIL slow_stable%0d req=%b we=%b addr=%0d wdata=%b exp 1 1 163 000", i, mem_req, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
    end
    wait_idle(ok2);
    total++; if (!ok2) begin bad++; $display("FAIL slow_idle timeout state=%s", state_name); end
    total++; if (wq.size() != wb + 2 || wq[wb] !== {A53, 3'b000} || wq[wb+1] !== {A53, 3'b101}) begin bad++; $display("FAIL slow_writes nwrites=%0d exp=2 (163/000, 163/101)", wq.size() - wb); end
    total++; if (rst_pulses - pb != 1) begin bad++; $display("FAIL slow_arm got=%0d exp=1", rst_pulses - pb); end
    lat = 1;
  endtask

  task automatic test_reset_in_read();
    bit ok = 1'b0;
    lat = 4;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL rstrd_read timeout state=%s", state_name); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstrd_busy got=%b exp=0", busy); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstrd_req got=%b exp=0", mem_req); end
    total++; if (timer_rst !== 1'b1) begin bad++; $display("FAIL rstrd_trst got=%b exp=1", timer_rst); end
    total++; if (cursor_shown !== 1'b0 || timer_init !== 1'b0 || mem_addr !== 10'd0) begin bad++; $display("FAIL rstrd_outs shown=%b init=%b addr=%0d exp 0 0 0", cursor_shown, timer_init, mem_addr); end
    enable = 1'b0;
    rst = 1'b0;
    lat = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_three_timeouts();
    test_move();
    test_disable();
    test_simultaneous();
    test_slow_memory();
    test_reset_in_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
